// File: rtl/mmp_spirx_scheduler_if.sv
// Bundle between the SPI receive scheduler and its surroundings: SPI pins,
// the FIFO push port and the status outputs.
interface mmp_spirx_scheduler_if;
   logic        spi_cs_n;
   logic        spi_clk;
   logic        spi_mosi;
   logic        fifo_fully;
   logic        push_s;
   logic [23:0] push_dt;
   logic        clr_stat;
   logic        frame_err;
   logic        ovf;
   logic [7:0]  drop_cnt;
   logic        busy;

   modport master (
      output spi_cs_n, spi_clk, spi_mosi, fifo_fully, clr_stat,
      input  push_s, push_dt, frame_err, ovf, drop_cnt, busy
   );

   modport slave (
      input  spi_cs_n, spi_clk, spi_mosi, fifo_fully, clr_stat,
      output push_s, push_dt, frame_err, ovf, drop_cnt, busy
   );
endinterface

// File: rtl/mmp_spirx_scheduler.sv
// SPI frame receiver and sole requester on the sound-command FIFO push port,
// arbitrating host frames against the internal MUTE write sequencer.
module mmp_spirx_scheduler #(
   parameter int          FRAME_BITS = 24,
   parameter logic [7:0]  DEV_PSG    = 8'h01,
   parameter logic [7:0]  DEV_OPLL   = 8'h02,
   parameter logic [7:0]  CMD_MUTE   = 8'hFF
) (
   input  logic               clk_SPIRX,
   input  logic               i_RST_n,
   mmp_spirx_scheduler_if.slave bus
);

   typedef enum logic [2:0] {IDLE, PUSH, GAP, MUTE_PUSH, MUTE_GAP} state_t;

   localparam logic [4:0] FRAME_BITS_C = 5'(FRAME_BITS);
   localparam logic [3:0] MUTE_WORDS   = 4'd12;
   // Synchroniser idle levels, bit order {sclk, cs_n, mosi}
   localparam logic [2:0] SYNC_RST     = 3'b110;

   logic [2:0] async_in;
   logic [2:0] sync1;
   logic [2:0] sync2;

   assign async_in = {bus.spi_clk, bus.spi_cs_n, bus.spi_mosi};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_sync
         logic [2:0] chain_reg;
         always_ff @(posedge clk_SPIRX) begin
            if (!i_RST_n)
               chain_reg <= {3{SYNC_RST[gi]}};
            else
               chain_reg <= {chain_reg[1:0], async_in[gi]};
         end
         assign sync1[gi] = chain_reg[1];
         assign sync2[gi] = chain_reg[2];
      end
   endgenerate

   logic sclk_rise, cs_fall, cs_rise, cs_low, mosi_bit;
   assign sclk_rise = sync1[2] & ~sync2[2];
   assign cs_fall   = ~sync1[1] & sync2[1];
   assign cs_rise   = sync1[1] & ~sync2[1];
   assign cs_low    = ~sync1[1];
   assign mosi_bit  = sync1[0];

   logic [23:0] shift_reg;
   logic [4:0]  bit_cnt_reg;

   always_ff @(posedge clk_SPIRX) begin
      if (!i_RST_n) begin
         shift_reg   <= '0;
         bit_cnt_reg <= '0;
      end else if (cs_fall) begin
         bit_cnt_reg <= '0;
      end else if (sclk_rise && cs_low) begin
         shift_reg <= {shift_reg[22:0], mosi_bit};
         if (bit_cnt_reg != 5'd31)
            bit_cnt_reg <= bit_cnt_reg + 5'd1;
      end
   end

   state_t      state_reg;
   logic        slot_full_reg;
   logic        slot_mute_reg;
   logic [23:0] slot_data_reg;
   logic [3:0]  mute_idx_reg;
   logic        push_s_reg;
   logic [23:0] push_dt_reg;
   logic        frame_err_reg;
   logic        ovf_reg;
   logic [7:0]  drop_cnt_reg;

   logic mute_active, slot_take, is_mute_cmd;
   logic frame_ok, frame_bad, frame_ovf, frame_acc, drop_evt;

   assign mute_active = (state_reg == MUTE_PUSH) || (state_reg == MUTE_GAP);
   // The slot empties this cycle if the FSM consumes it; a new frame may then refill it
   assign slot_take   = (state_reg == IDLE) && slot_full_reg &&
                        (slot_mute_reg || !bus.fifo_fully);
   assign is_mute_cmd = (shift_reg[23:16] == CMD_MUTE);
   assign frame_ok    = cs_rise && (bit_cnt_reg == FRAME_BITS_C);
   assign frame_bad   = cs_rise && (bit_cnt_reg != FRAME_BITS_C);
   assign frame_ovf   = frame_ok && ((slot_full_reg && !slot_take) ||
                                     (is_mute_cmd && mute_active));
   assign frame_acc   = frame_ok && !frame_ovf;
   assign drop_evt    = frame_bad || frame_ovf;

   function automatic logic [23:0] mute_word(input logic [3:0] idx);
      if (idx < 4'd3)
         return {DEV_PSG, 8'h08 + {4'd0, idx}, 8'h00};
      else
         return {DEV_OPLL, 8'h30 + {4'd0, idx} - 8'd3, 8'h0F};
   endfunction

   always_ff @(posedge clk_SPIRX) begin
      if (!i_RST_n) begin
         slot_full_reg <= 1'b0;
         slot_mute_reg <= 1'b0;
         slot_data_reg <= '0;
      end else if (frame_acc) begin
         slot_full_reg <= 1'b1;
         slot_mute_reg <= is_mute_cmd;
         slot_data_reg <= shift_reg;
      end else if (slot_take) begin
         slot_full_reg <= 1'b0;
         slot_mute_reg <= 1'b0;
      end
   end

   // A new drop in the clearing cycle survives the clear
   always_ff @(posedge clk_SPIRX) begin
      if (!i_RST_n) begin
         frame_err_reg <= 1'b0;
         ovf_reg       <= 1'b0;
         drop_cnt_reg  <= '0;
      end else if (bus.clr_stat) begin
         frame_err_reg <= frame_bad;
         ovf_reg       <= frame_ovf;
         drop_cnt_reg  <= drop_evt ? 8'd1 : 8'd0;
      end else begin
         if (frame_bad)
            frame_err_reg <= 1'b1;
         if (frame_ovf)
            ovf_reg <= 1'b1;
         if (drop_evt && drop_cnt_reg != 8'hFF)
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
      end
   end

   // mute_idx_reg holds the index of the next MUTE word still to be pushed
   always_ff @(posedge clk_SPIRX) begin
      if (!i_RST_n) begin
         state_reg    <= IDLE;
         push_s_reg   <= 1'b0;
         push_dt_reg  <= '0;
         mute_idx_reg <= '0;
      end else begin
         push_s_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (slot_take) begin
                  if (slot_mute_reg) begin
                     if (!bus.fifo_fully) begin
                        state_reg    <= MUTE_PUSH;
                        push_s_reg   <= 1'b1;
                        push_dt_reg  <= mute_word(4'd0);
                        mute_idx_reg <= 4'd1;
                     end else begin
                        state_reg    <= MUTE_GAP;
                        mute_idx_reg <= 4'd0;
                     end
                  end else begin
                     state_reg   <= PUSH;
                     push_s_reg  <= 1'b1;
                     push_dt_reg <= slot_data_reg;
                  end
               end
            end
            PUSH:      state_reg <= GAP;
            GAP:       state_reg <= IDLE;
            MUTE_PUSH: state_reg <= MUTE_GAP;
            MUTE_GAP: begin
               if (mute_idx_reg == MUTE_WORDS) begin
                  state_reg <= IDLE;
               end else if (!bus.fifo_fully) begin
                  state_reg    <= MUTE_PUSH;
                  push_s_reg   <= 1'b1;
                  push_dt_reg  <= mute_word(mute_idx_reg);
                  mute_idx_reg <= mute_idx_reg + 4'd1;
               end
            end
            default:   state_reg <= IDLE;
         endcase
      end
   end

   assign bus.push_s    = push_s_reg;
   assign bus.push_dt   = push_dt_reg;
   assign bus.frame_err = frame_err_reg;
   assign bus.ovf       = ovf_reg;
   assign bus.drop_cnt  = drop_cnt_reg;
   assign bus.busy      = slot_full_reg | mute_active;

endmodule

// File: tb/tb_mmp_spirx_scheduler.sv
// Scoreboard bench for mmp_spirx_scheduler: expected push words are queued as
// frames are sent and compared in order as the DUT strobes the push port.
module tb_mmp_spirx_scheduler;

   logic clk_SPIRX = 1'b0;
   logic i_RST_n   = 1'b0;

   always #5 clk_SPIRX = ~clk_SPIRX;

   mmp_spirx_scheduler_if bus ();

   mmp_spirx_scheduler dut (
      .clk_SPIRX (clk_SPIRX),
      .i_RST_n   (i_RST_n),
      .bus       (bus)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [23:0] exp_q[$];
   int          cyc = 0;
   int          push_count = 0;
   int          last_push_cyc = 0;
   bit          chk_gap = 1'b0;
   bit          have_last = 1'b0;
   logic        fully_prev = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_SPIRX);
   endtask

   always @(posedge clk_SPIRX) fully_prev <= bus.fifo_fully;

   // Push monitor: one line per push, every push checked against the scoreboard
   always @(negedge clk_SPIRX) begin
      logic [23:0] w;
      cyc++;
      if (bus.push_s === 1'b1) begin
         $display("[%0d] push %06h", cyc, bus.push_dt);
         check_val("push_while_full", 32'(fully_prev), 0);
         check_val("sb_has_entry", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            check_val("push_dt", 32'(bus.push_dt), 32'(w));
         end
         if (chk_gap && have_last)
            check_val("push_gap", cyc - last_push_cyc, 2);
         have_last     = 1'b1;
         last_push_cyc = cyc;
         push_count++;
      end
   end

   task automatic send_frame(input logic [31:0] val, input int nbits);
      bus.spi_cs_n = 1'b1;
      tick(4);
      bus.spi_cs_n = 1'b0;
      tick(4);
      for (int i = nbits - 1; i >= 0; i--) begin
         bus.spi_mosi = val[i];
         tick(4);
         bus.spi_clk = 1'b1;
         tick(4);
         bus.spi_clk = 1'b0;
      end
      tick(4);
      bus.spi_cs_n = 1'b1;
   endtask

   task automatic wait_drain(input int budget);
      int k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         tick(1);
         k++;
      end
      tick(10);
      check_val("sb_drained", exp_q.size(), 0);
   endtask

   task automatic wait_pushes(input int target, input int budget);
      int k = 0;
      while (push_count < target && k < budget) begin
         tick(1);
         k++;
      end
      check_val("push_reached", 32'(push_count >= target), 1);
   endtask

   task automatic clear_stat();
      bus.clr_stat = 1'b1;
      tick(1);
      bus.clr_stat = 1'b0;
   endtask

   task automatic queue_mute_words();
      for (int i = 0; i < 12; i++) begin
         if (i < 3)
            exp_q.push_back(24'h010800 + 24'(i << 8));
         else
            exp_q.push_back(24'h02300F + 24'((i - 3) << 8));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pc0;
      bus.spi_cs_n   = 1'b1;
      bus.spi_clk    = 1'b0;
      bus.spi_mosi   = 1'b0;
      bus.fifo_fully = 1'b0;
      bus.clr_stat   = 1'b0;
      tick(5);
      check_val("rst_push_s",    32'(bus.push_s), 0);
      check_val("rst_push_dt",   32'(bus.push_dt), 0);
      check_val("rst_frame_err", 32'(bus.frame_err), 0);
      check_val("rst_ovf",       32'(bus.ovf), 0);
      check_val("rst_drop_cnt",  32'(bus.drop_cnt), 0);
      check_val("rst_busy",      32'(bus.busy), 0);
      i_RST_n = 1'b1;
      tick(5);

      // Single valid frame: push two cycles after the synchronised CS_n rise
      exp_q.push_back(24'h01080F);
      send_frame(32'h0001080F, 24);
      tick(3);
      check_val("lat_early", 32'(bus.push_s), 0);
      tick(1);
      check_val("lat_push", 32'(bus.push_s), 1);
      wait_drain(50);
      check_val("t1_frame_err", 32'(bus.frame_err), 0);
      check_val("t1_drop_cnt",  32'(bus.drop_cnt), 0);

      // Malformed frames
      pc0 = push_count;
      send_frame(32'h00123456, 23);
      tick(6);
      check_val("t2_err_23",  32'(bus.frame_err), 1);
      check_val("t2_drop_23", 32'(bus.drop_cnt), 1);
      send_frame(32'h01123456, 25);
      tick(6);
      check_val("t2_err_25",  32'(bus.frame_err), 1);
      check_val("t2_drop_25", 32'(bus.drop_cnt), 2);
      check_val("t2_no_push", push_count, pc0);
      // Clear coincident with a new error: the error wins
      send_frame(32'h000002AA, 10);
      tick(2);
      bus.clr_stat = 1'b1;
      tick(1);
      bus.clr_stat = 1'b0;
      tick(3);
      check_val("t2_clr_err",  32'(bus.frame_err), 1);
      check_val("t2_clr_drop", 32'(bus.drop_cnt), 1);
      clear_stat();
      tick(2);
      check_val("t2_cleared", 32'(bus.drop_cnt), 0);

      // FIFO full: second frame is dropped, first waits in the slot
      bus.fifo_fully = 1'b1;
      exp_q.push_back(24'h011122);
      send_frame(32'h00011122, 24);
      send_frame(32'h00013344, 24);
      tick(6);
      check_val("t3_ovf",  32'(bus.ovf), 1);
      check_val("t3_drop", 32'(bus.drop_cnt), 1);
      check_val("t3_busy", 32'(bus.busy), 1);
      check_val("t3_err",  32'(bus.frame_err), 0);
      bus.fifo_fully = 1'b0;
      wait_drain(100);
      tick(20);
      check_val("t3_idle", 32'(bus.busy), 0);
      clear_stat();

      // MUTE sequence: 12 words, pushes exactly 2 cycles apart
      queue_mute_words();
      have_last = 1'b0;
      chk_gap   = 1'b1;
      send_frame(32'h00FF0000, 24);
      wait_drain(200);
      chk_gap = 1'b0;
      check_val("t4_ovf",  32'(bus.ovf), 0);
      check_val("t4_busy", 32'(bus.busy), 0);

      // Frame arriving during a stalled MUTE is pushed after it
      queue_mute_words();
      exp_q.push_back(24'h020510);
      pc0 = push_count;
      fork
         begin
            send_frame(32'h00FF0000, 24);
            send_frame(32'h00020510, 24);
         end
         begin
            wait_pushes(pc0 + 3, 2000);
            bus.fifo_fully = 1'b1;
            tick(300);
            check_val("t5_busy_stall", 32'(bus.busy), 1);
            check_val("t5_stalled", push_count, pc0 + 3);
            bus.fifo_fully = 1'b0;
         end
      join
      wait_drain(300);
      check_val("t5_ovf", 32'(bus.ovf), 0);

      // Reset in the middle of MUTE, CS_n held low through reset release
      queue_mute_words();
      pc0 = push_count;
      send_frame(32'h00FF0000, 24);
      wait_pushes(pc0 + 4, 200);
      i_RST_n      = 1'b0;
      bus.spi_cs_n = 1'b0;
      @(posedge clk_SPIRX);
      exp_q.delete();
      @(negedge clk_SPIRX);
      check_val("t6_push_s",   32'(bus.push_s), 0);
      check_val("t6_push_dt",  32'(bus.push_dt), 0);
      check_val("t6_busy",     32'(bus.busy), 0);
      check_val("t6_drop_cnt", 32'(bus.drop_cnt), 0);
      check_val("t6_err",      32'(bus.frame_err), 0);
      tick(5);
      i_RST_n = 1'b1;
      tick(10);
      pc0 = push_count;
      bus.spi_cs_n = 1'b1;
      tick(8);
      check_val("t6_partial_err",  32'(bus.frame_err), 1);
      check_val("t6_partial_drop", 32'(bus.drop_cnt), 1);
      check_val("t6_no_push",      push_count, pc0);

      // Drop counter saturation
      for (int k = 0; k < 300; k++) begin
         bus.spi_cs_n = 1'b0;
         tick(4);
         bus.spi_cs_n = 1'b1;
         tick(4);
      end
      tick(6);
      check_val("t7_drop_sat", 32'(bus.drop_cnt), 32'h0000_00FF);
      check_val("t7_err",      32'(bus.frame_err), 1);
      check_val("t7_no_push",  push_count, pc0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
